// File: rtl/monarch_pkg.sv
// monarch_pkg: command record and dispatcher state encoding shared by the monarch blocks
package monarch_pkg;
  localparam int CMD_DATA_W = 8;
  localparam int CMD_ADDR_W = 8;
  localparam int CMD_CORE_W = 2;
  typedef struct packed {
    logic [CMD_DATA_W-1:0] data;
    logic [CMD_ADDR_W-1:0] address;
    logic [CMD_CORE_W-1:0] core;
    logic                  broadcast;
  } monarch_cmd_t;
  typedef enum logic [1:0] {IDLE, WAIT, ISSUE} dispatch_state_t;
endpackage

// File: rtl/monarch_dispatcher_if.sv
// monarch_dispatcher_if: host command channel plus the shared per-core write bus
interface monarch_dispatcher_if #(
  parameter int NUM_CORES = 4,
  parameter int CORE_ID_BIT_WIDTH = 2,
  parameter int MONARCH_DATA_BIT_WIDTH = 8,
  parameter int MONARCH_ADDRESS_BIT_WIDTH = 8
);
  logic [MONARCH_DATA_BIT_WIDTH-1:0]    host_tdata;
  logic [MONARCH_ADDRESS_BIT_WIDTH-1:0] host_taddress;
  logic [CORE_ID_BIT_WIDTH-1:0]         host_tcore;
  logic                                 host_tbroadcast;
  logic                                 host_tvalid;
  logic                                 host_tready;
  logic [MONARCH_DATA_BIT_WIDTH-1:0]    monarch_axi_tdata;
  logic [MONARCH_ADDRESS_BIT_WIDTH-1:0] monarch_axi_taddress;
  logic [NUM_CORES-1:0]                 monarch_axi_tvalid;
  logic [NUM_CORES-1:0]                 monarch_axi_tready;
  modport master (
    output host_tdata, host_taddress, host_tcore, host_tbroadcast, host_tvalid, monarch_axi_tready,
    input  host_tready, monarch_axi_tdata, monarch_axi_taddress, monarch_axi_tvalid
  );
  modport slave (
    input  host_tdata, host_taddress, host_tcore, host_tbroadcast, host_tvalid, monarch_axi_tready,
    output host_tready, monarch_axi_tdata, monarch_axi_taddress, monarch_axi_tvalid
  );
endinterface

// File: rtl/monarch_cmd_fifo.sv
// monarch_cmd_fifo: command buffer without fall-through; head is valid whenever count is non-zero
module monarch_cmd_fifo import monarch_pkg::*; #(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     resetn,
  input  logic                     push,
  input  monarch_cmd_t             push_cmd,
  input  logic                     pop,
  output monarch_cmd_t             head,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  monarch_cmd_t mem [DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic do_push, do_pop;
  assign full = count == CW'(DEPTH);
  assign do_push = push && !full;
  assign do_pop = pop && count != '0;
  assign head = mem[rd_ptr];
  // pointers wrap naturally at the power-of-two depth; push while popping leaves count unchanged
  always_ff @(posedge clk) begin
    if (!resetn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PW'(1);
      if (do_pop) rd_ptr <= rd_ptr + PW'(1);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end
  // storage needs no reset, occupancy alone decides what is valid
  always_ff @(posedge clk) if (do_push) mem[wr_ptr] <= push_cmd;
endmodule

// File: rtl/monarch_dispatcher.sv
// monarch_dispatcher: buffers host register writes and strobes each into its ready target core(s)
module monarch_dispatcher import monarch_pkg::*; #(
  parameter int NUM_CORES = 4,
  parameter int CORE_ID_BIT_WIDTH = CMD_CORE_W,
  parameter int MONARCH_DATA_BIT_WIDTH = CMD_DATA_W,
  parameter int MONARCH_ADDRESS_BIT_WIDTH = CMD_ADDR_W,
  parameter int FIFO_DEPTH = 4,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic                          clk,
  input  logic                          resetn,
  monarch_dispatcher_if.slave           bus,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          dispatch_busy,
  output logic                          error_bad_core,
  output logic                          error_timeout
);
  localparam int TW = $clog2(TIMEOUT_CYCLES);
  dispatch_state_t state;
  monarch_cmd_t push_cmd, head;
  logic full, pop, head_bad, ready_ok;
  logic [CORE_ID_BIT_WIDTH-1:0] head_core;
  logic [NUM_CORES-1:0] mask, head_mask;
  logic [TW-1:0] timer;
  assign push_cmd = '{
    data:      CMD_DATA_W'(bus.host_tdata),
    address:   CMD_ADDR_W'(bus.host_taddress),
    core:      CMD_CORE_W'(bus.host_tcore),
    broadcast: bus.host_tbroadcast
  };
  monarch_cmd_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk(clk),
    .resetn(resetn),
    .push(bus.host_tvalid),
    .push_cmd(push_cmd),
    .pop(pop),
    .head(head),
    .count(fifo_count),
    .full(full)
  );
  assign bus.host_tready = !full;
  assign pop = state == IDLE && fifo_count != '0;
  assign head_core = CORE_ID_BIT_WIDTH'(head.core);
  assign head_bad = !head.broadcast && int'(head_core) >= NUM_CORES;
  assign head_mask = head.broadcast ? '1 : NUM_CORES'(1) << head_core;
  assign ready_ok = (bus.monarch_axi_tready & mask) == mask;
  assign dispatch_busy = fifo_count != '0 || state != IDLE;
  // load the head, wait for every target to be idle (or give up), then strobe exactly one cycle
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state <= IDLE;
      mask <= '0;
      timer <= '0;
      bus.monarch_axi_tvalid <= '0;
      bus.monarch_axi_tdata <= '0;
      bus.monarch_axi_taddress <= '0;
      error_bad_core <= 1'b0;
      error_timeout <= 1'b0;
    end else begin
      error_bad_core <= 1'b0;
      error_timeout <= 1'b0;
      case (state)
        IDLE: if (pop) begin
          bus.monarch_axi_tdata <= MONARCH_DATA_BIT_WIDTH'(head.data);
          bus.monarch_axi_taddress <= MONARCH_ADDRESS_BIT_WIDTH'(head.address);
          mask <= head_mask;
          if (head_bad) error_bad_core <= 1'b1;
          else begin
            timer <= '0;
            state <= WAIT;
          end
        end
        WAIT: if (ready_ok) begin
          bus.monarch_axi_tvalid <= mask;
          state <= ISSUE;
        end else if (timer == TW'(TIMEOUT_CYCLES - 1)) begin
          error_timeout <= 1'b1;
          state <= IDLE;
        end else timer <= timer + TW'(1);
        ISSUE: begin
          bus.monarch_axi_tvalid <= '0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_monarch_dispatcher.sv
// tb_monarch_dispatcher: directed tests on two dispatchers checked against a queue-based reference
module tb_monarch_dispatcher;
  typedef struct packed {
    logic [7:0] data;
    logic [7:0] addr;
    logic [1:0] core;
    logic       bc;
  } tcmd_t;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  always #5 clk = ~clk;

  logic       h_valid[2], h_bc[2];
  logic [1:0] h_core[2];
  logic [7:0] h_data[2], h_addr[2];
  logic [3:0] rdy[2];

  monarch_dispatcher_if #(.NUM_CORES(4)) ifa ();
  monarch_dispatcher_if #(.NUM_CORES(3)) ifb ();
  assign ifa.host_tvalid = h_valid[0];
  assign ifa.host_tbroadcast = h_bc[0];
  assign ifa.host_tcore = h_core[0];
  assign ifa.host_tdata = h_data[0];
  assign ifa.host_taddress = h_addr[0];
  assign ifa.monarch_axi_tready = rdy[0];
  assign ifb.host_tvalid = h_valid[1];
  assign ifb.host_tbroadcast = h_bc[1];
  assign ifb.host_tcore = h_core[1];
  assign ifb.host_tdata = h_data[1];
  assign ifb.host_taddress = h_addr[1];
  assign ifb.monarch_axi_tready = rdy[1][2:0];

  logic [3:0] a_tv[2];
  logic [7:0] a_data[2], a_addr[2];
  logic [2:0] a_cnt[2];
  logic       a_busy[2], a_bad[2], a_to[2], a_rdy[2];
  assign a_tv[0] = ifa.monarch_axi_tvalid;
  assign a_tv[1] = {1'b0, ifb.monarch_axi_tvalid};
  assign a_data[0] = ifa.monarch_axi_tdata;
  assign a_data[1] = ifb.monarch_axi_tdata;
  assign a_addr[0] = ifa.monarch_axi_taddress;
  assign a_addr[1] = ifb.monarch_axi_taddress;
  assign a_rdy[0] = ifa.host_tready;
  assign a_rdy[1] = ifb.host_tready;

  monarch_dispatcher dut_a (
    .clk(clk), .resetn(resetn), .bus(ifa),
    .fifo_count(a_cnt[0]), .dispatch_busy(a_busy[0]),
    .error_bad_core(a_bad[0]), .error_timeout(a_to[0])
  );
  monarch_dispatcher #(.NUM_CORES(3), .TIMEOUT_CYCLES(8)) dut_b (
    .clk(clk), .resetn(resetn), .bus(ifb),
    .fifo_count(a_cnt[1]), .dispatch_busy(a_busy[1]),
    .error_bad_core(a_bad[1]), .error_timeout(a_to[1])
  );

  int passed = 0;
  int total = 0;
  task automatic check(input string name, input int i, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s[%0d]: got %0h expected %0h at %0t", name, i, act, exp, $time);
  endtask

  // reference: a queue of pending writes plus the one command currently owning the bus
  int         nc[2] = '{4, 3};
  int         tmo[2] = '{256, 8};
  tcmd_t      mq[2][$];
  tcmd_t      mc;
  logic [3:0] e_tv[2], tmask[2];
  logic [7:0] e_data[2], e_addr[2];
  logic       e_bad[2], e_to[2], m_busy[2], m_strobed[2];
  int         waited[2];
  logic       room;
  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      room = mq[i].size() < 4;
      e_bad[i] = 1'b0;
      e_to[i] = 1'b0;
      if (!resetn) begin
        mq[i].delete();
        m_busy[i] = 1'b0;
        m_strobed[i] = 1'b0;
        e_tv[i] = '0;
        e_data[i] = '0;
        e_addr[i] = '0;
        tmask[i] = '0;
        waited[i] = 0;
      end else begin
        if (m_strobed[i]) begin
          e_tv[i] = '0;
          m_strobed[i] = 1'b0;
          m_busy[i] = 1'b0;
        end else if (m_busy[i]) begin
          if ((rdy[i] & tmask[i]) == tmask[i]) begin
            e_tv[i] = tmask[i];
            m_strobed[i] = 1'b1;
          end else if (waited[i] == tmo[i] - 1) begin
            e_to[i] = 1'b1;
            m_busy[i] = 1'b0;
          end else waited[i]++;
        end else if (mq[i].size() != 0) begin
          mc = mq[i].pop_front();
          e_data[i] = mc.data;
          e_addr[i] = mc.addr;
          if (!mc.bc && int'(mc.core) >= nc[i]) e_bad[i] = 1'b1;
          else begin
            m_busy[i] = 1'b1;
            waited[i] = 0;
            tmask[i] = mc.bc ? 4'((1 << nc[i]) - 1) : 4'(1 << mc.core);
          end
        end
        if (h_valid[i] && room) mq[i].push_back('{data: h_data[i], addr: h_addr[i], core: h_core[i], bc: h_bc[i]});
      end
    end
  end

  // every cycle after the first reset, each dispatcher's outputs must equal the reference
  logic chk = 1'b0;
  always @(negedge clk) begin
    if (chk) for (int i = 0; i < 2; i++) begin
      check("tvalid", i, 32'(a_tv[i]), 32'(e_tv[i]));
      check("tdata", i, 32'(a_data[i]), 32'(e_data[i]));
      check("taddress", i, 32'(a_addr[i]), 32'(e_addr[i]));
      check("error_bad_core", i, 32'(a_bad[i]), 32'(e_bad[i]));
      check("error_timeout", i, 32'(a_to[i]), 32'(e_to[i]));
      check("fifo_count", i, 32'(a_cnt[i]), 32'(mq[i].size()));
      check("dispatch_busy", i, 32'(a_busy[i]), 32'(mq[i].size() != 0 || m_busy[i]));
      check("host_tready", i, 32'(a_rdy[i]), 32'(mq[i].size() != 4));
    end
  end

  // record what the cores actually captured and which errors were raised
  int         strobes[2] = '{0, 0};
  int         bad_cnt[2] = '{0, 0};
  int         to_cnt[2] = '{0, 0};
  logic [7:0] logd[2][$];
  logic [3:0] lastm[2];
  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (a_tv[i] != '0) begin
        strobes[i]++;
        logd[i].push_back(a_data[i]);
        lastm[i] = a_tv[i];
      end
      if (a_bad[i]) bad_cnt[i]++;
      if (a_to[i]) to_cnt[i]++;
    end
  end

  task automatic send(input int i, input logic [1:0] core, input logic bc, input logic [7:0] addr, input logic [7:0] data);
    @(negedge clk);
    h_valid[i] = 1'b1;
    h_core[i] = core;
    h_bc[i] = bc;
    h_addr[i] = addr;
    h_data[i] = data;
    @(negedge clk);
    h_valid[i] = 1'b0;
  endtask

  int s, t, b;
  initial begin
    for (int i = 0; i < 2; i++) begin
      h_valid[i] = 1'b0;
      h_bc[i] = 1'b0;
      h_core[i] = '0;
      h_data[i] = '0;
      h_addr[i] = '0;
      rdy[i] = 4'hF;
    end
    rdy[1] = 4'h7;
    repeat (2) @(negedge clk);
    chk = 1'b1;
    @(negedge clk) resetn = 1'b1;
    check("rst_tvalid", 0, 32'(a_tv[0]), 32'h0);
    check("rst_count", 0, 32'(a_cnt[0]), 32'h0);
    check("rst_tready", 0, 32'(a_rdy[0]), 32'h1);
    check("rst_busy", 0, 32'(a_busy[0]), 32'h0);

    send(0, 2'd2, 1'b0, 8'h03, 8'h10);
    repeat (2) @(posedge clk);
    #1;
    check("single_tvalid", 0, 32'(a_tv[0]), 32'b0100);
    check("single_tdata", 0, 32'(a_data[0]), 32'h10);
    check("single_taddress", 0, 32'(a_addr[0]), 32'h03);
    @(posedge clk);
    #1 check("single_fall", 0, 32'(a_tv[0]), 32'h0);

    repeat (3) @(negedge clk);
    send(0, 2'd0, 1'b1, 8'h01, 8'hAA);
    repeat (2) @(posedge clk);
    #1;
    check("bcast_tvalid", 0, 32'(a_tv[0]), 32'hF);
    check("bcast_tdata", 0, 32'(a_data[0]), 32'hAA);
    repeat (3) @(negedge clk);
    rdy[0] = 4'b1101;
    s = strobes[0];
    send(0, 2'd0, 1'b1, 8'h02, 8'hBB);
    repeat (10) @(negedge clk);
    check("bcast_held", 0, 32'(strobes[0] - s), 32'h0);
    rdy[0] = 4'hF;
    @(posedge clk);
    #1;
    check("bcast_release", 0, 32'(a_tv[0]), 32'hF);
    check("bcast_release_data", 0, 32'(a_data[0]), 32'hBB);

    repeat (3) @(negedge clk);
    rdy[0] = 4'h0;
    s = logd[0].size();
    for (int k = 0; k < 6; k++) begin
      send(0, 2'(k), 1'b0, 8'(8'h20 + k), 8'(8'h21 + k));
      if (k == 3) check("bp_count_after_load", 0, 32'(a_cnt[0]), 32'd3);
      if (k == 4) check("bp_tready_full", 0, 32'(a_rdy[0]), 32'h0);
    end
    check("bp_count_full", 0, 32'(a_cnt[0]), 32'd4);
    rdy[0] = 4'hF;
    repeat (25) @(negedge clk);
    check("bp_deliveries", 0, 32'(logd[0].size() - s), 32'd5);
    for (int j = 0; j < 5; j++) check("bp_order", 0, 32'(logd[0][s + j]), 32'(8'h21 + j));

    rdy[1] = 4'b0101;
    s = logd[1].size();
    t = to_cnt[1];
    send(1, 2'd1, 1'b0, 8'h31, 8'h31);
    send(1, 2'd0, 1'b0, 8'h32, 8'h32);
    repeat (20) @(negedge clk);
    check("to_pulses", 1, 32'(to_cnt[1] - t), 32'd1);
    check("to_deliveries", 1, 32'(logd[1].size() - s), 32'd1);
    check("to_next_data", 1, 32'(logd[1][s]), 32'h32);
    check("to_next_mask", 1, 32'(lastm[1]), 32'b001);

    rdy[1] = 4'h7;
    s = logd[1].size();
    b = bad_cnt[1];
    send(1, 2'd3, 1'b0, 8'h41, 8'h41);
    send(1, 2'd2, 1'b0, 8'h42, 8'h42);
    repeat (10) @(negedge clk);
    check("bad_pulses", 1, 32'(bad_cnt[1] - b), 32'd1);
    check("bad_deliveries", 1, 32'(logd[1].size() - s), 32'd1);
    check("bad_next_data", 1, 32'(logd[1][s]), 32'h42);
    check("bad_next_mask", 1, 32'(lastm[1]), 32'b100);

    rdy[0] = 4'h0;
    s = strobes[0];
    send(0, 2'd0, 1'b0, 8'h51, 8'h51);
    send(0, 2'd1, 1'b0, 8'h52, 8'h52);
    send(0, 2'd2, 1'b0, 8'h53, 8'h53);
    check("rw_queued", 0, 32'(a_cnt[0]), 32'd2);
    @(negedge clk) resetn = 1'b0;
    @(negedge clk) resetn = 1'b1;
    check("rw_count", 0, 32'(a_cnt[0]), 32'h0);
    check("rw_tvalid", 0, 32'(a_tv[0]), 32'h0);
    check("rw_busy", 0, 32'(a_busy[0]), 32'h0);
    rdy[0] = 4'hF;
    repeat (10) @(negedge clk);
    check("rw_no_strobe", 0, 32'(strobes[0] - s), 32'h0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
